// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - 8-lane round-robin arbiter with registered valid/ready output
// Captures one lane per transfer with rotating priority and presents it as a single stream.
module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [7:0]       eligible;
  logic             arb;
  logic             found;
  logic [2:0]       win;
  logic [2:0]       idx;
  logic [WIDTH-1:0] win_data;

  // The lane granted this cycle still has req high, so it must not win again.
  assign eligible = req & ~gnt;
  assign arb      = (state == IDLE) || (state == SEND && out_valid && out_ready);
  assign busy     = (state == SEND);

  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_data = in_data[int'(win)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      gnt       <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (arb && found) begin
      state     <= SEND;
      out_data  <= win_data;
      sel       <= win;
      gnt       <= 8'd1 << win;
      out_valid <= 1'b1;
      ptr       <= win + 3'd1;
    end else begin
      gnt <= 8'd0;
      if (arb && state == SEND) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [63:0] in_data;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [7:0]  lane [8];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] l;
    logic [7:0] d;
  } exp_t;
  exp_t sb [$];

  mux_rr_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = lane[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int l, input logic [7:0] d);
    sb.push_back({3'(l), d});
  endtask

  // Advance one edge, then score any grant against the next queued capture.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    check("busy_eq_valid", 32'(busy), 32'(out_valid));
    if (gnt !== 8'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_gnt", 32'(gnt), 32'(8'd1 << e.l));
        check("sb_sel", 32'(sel), 32'(e.l));
        check("sb_data", 32'(out_data), 32'(e.d));
        check("sb_valid", 32'(out_valid), 32'd1);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) lane[i] = 8'h10 + 8'(i);
    rst_n = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;

    // Reset held three cycles with every lane requesting.
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_idle("rst");
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
    end

    // Full load after release: lanes 0..7 then 0, back to back.
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(i % 8, 8'h10 + 8'(i % 8));
      cyc();
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_gnt_seen", 32'(gnt != 8'd0), 32'd1);
    end
    req = 8'h00;
    cyc();
    expect_idle("full_end");

    // Single request on lane 5, requester drops req after gnt.
    lane[5] = 8'hA5;
    req = 8'h20;
    push(5, 8'hA5);
    cyc();
    check("single_gnt", 32'(gnt), 32'h20);
    req = 8'h00;
    cyc();
    expect_idle("single_end");
    lane[5] = 8'h15;

    // Backpressure on a lane-2 capture, then release loads lane 3 at the same edge.
    lane[2] = 8'h3C;
    req = 8'h04;
    push(2, 8'h3C);
    cyc();
    out_ready = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_sel", 32'(sel), 32'd2);
      check("bp_gnt", 32'(gnt), 32'd0);
    end
    out_ready = 1'b1;
    push(3, 8'h13);
    cyc();
    check("bp_reload_valid", 32'(out_valid), 32'd1);
    check("bp_reload_gnt", 32'(gnt), 32'h08);
    req = 8'h00;
    cyc();
    expect_idle("bp_end");
    lane[2] = 8'h12;

    // Pointer wrap: lane 7 grant, then lanes 0,7,0 with req=81.
    req = 8'h80;
    push(7, 8'h17);
    cyc();
    req = 8'h81;
    push(0, 8'h10);
    cyc();
    check("wrap_gnt0", 32'(gnt), 32'h01);
    push(7, 8'h17);
    cyc();
    check("wrap_gnt7", 32'(gnt), 32'h80);
    push(0, 8'h10);
    cyc();
    check("wrap_gnt0b", 32'(gnt), 32'h01);
    req = 8'h00;
    cyc();
    expect_idle("wrap_end");

    // Reset while holding a word under backpressure.
    req = 8'h08;
    push(3, 8'h13);
    cyc();
    out_ready = 1'b0;
    req = 8'h22;
    cyc();
    check("mid_hold_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    cyc();
    expect_idle("mid_rst");
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(1, 8'h11);
    cyc();
    check("mid_first_gnt", 32'(gnt), 32'h02);
    req = 8'h20;
    push(5, 8'h15);
    cyc();
    check("mid_second_gnt", 32'(gnt), 32'h20);
    req = 8'h00;
    cyc();
    expect_idle("mid_end");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the 8:1 lane multiplexer. Eight requesters each present a WIDTH-bit lane and a request line. The block picks one lane per transfer with rotating priority, drives the 3-bit select, and registers the selected lane onto a single valid/ready output. It sits between the lane sources and the shared downstream consumer, so the consumer sees one flow-controlled stream.

## Interface
- WIDTH, 8, bit width of each lane and of the output data.
- clk  in  1  rising-edge clock; all state updates on this edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  8  request lines; bit i = lane i has data.
- in_data  in  8*WIDTH  packed lanes; lane i = in_data[i*WIDTH +: WIDTH].
- gnt  out  8  one-hot accept pulse, one cycle, to the requester whose lane was captured.
- sel  out  3  select of the captured lane (sel[2] MSB); drives the mux select pins.
- out_valid  out  1  out_data holds an untransferred word.
- out_data  out  WIDTH  registered selected lane.
- out_ready  in  1  consumer accepts out_data when high with out_valid.
- busy  out  1  high in SEND state (same as out_valid).

## Operation
- States:
  - IDLE: no word held.
  - SEND: word held, out_valid=1.
- Priority pointer ptr[2:0] names the highest-priority lane.
- Search order: ptr, ptr+1, …, ptr+7, modulo 8.
- Eligible mask: req & ~(gnt_active ? gnt : 0). The lane granted in the current cycle is masked, because its req is still high in that cycle.
- Arbitrate event: (state==IDLE) or (state==SEND and out_valid and out_ready).
- On an arbitrate event with eligible != 0, winner w = first eligible lane in search order. At the edge:
  - out_data <= lane w
  - sel <= w
  - gnt <= 1<<w
  - out_valid <= 1
  - ptr <= w+1 (mod 8, so 7 wraps to 0)
  - state <= SEND
- On an arbitrate event with eligible == 0:
  - If in SEND (handshake): out_valid <= 0, state <= IDLE.
  - gnt <= 0.
- SEND without a handshake: out_data, sel and out_valid hold. gnt <= 0, so gnt is never high two cycles for the same capture.
- Requester contract:
  - Hold req[i] and lane i stable until gnt[i] is seen.
  - Lane data is captured at the granting edge, so the requester is free after gnt.
- Fairness: a lane whose req stays high is granted within 8 grants.
- busy = (state==SEND).

## Timing
- Reset (rst_n=0 at an edge), regardless of state:
  - state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, gnt=0.
  - req is ignored during reset.
  - A held word is discarded with no gnt.
- Latency: req rises before edge k (IDLE) → gnt, out_valid, sel and out_data valid after edge k, i.e. one cycle.
- gnt and the first cycle of out_valid for a capture coincide.
- Throughput: with out_ready=1 and eligible requests, one transfer per cycle (back-to-back reload in SEND). In the worst case it falls to one transfer per 2 cycles (IDLE visited).
- Handshake and a new request in the same cycle: the old word completes and the new word loads at the same edge; out_valid stays 1.
- A handshake in the gnt cycle masks the same lane. If only that lane requests, go to IDLE.
- All outputs are registered; there is no combinational path from req, in_data or out_ready to any output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=8'hFF, out_ready=1.
  - All outputs stay 0, gnt=0.
  - First grant after release is lane 0.
- Single request: req=8'h20, lane5=8'hA5, out_ready=1.
  - Next edge: gnt=8'h20, sel=3'b101, out_data=8'hA5, out_valid=1.
  - Requester drops req, so the following edge gives out_valid=0, gnt=0.
- Full load: req=8'hFF held, distinct lane values 8'h10..8'h17, out_ready=1.
  - One gnt per cycle in lane order 0,1,…,7,0.
  - out_data tracks 8'h10..8'h17; out_valid continuously 1.
- Backpressure: capture lane 2 (8'h3C), then hold out_ready=0 for 5 cycles with req=8'hFF.
  - out_valid=1, out_data=8'h3C, sel=2 stable; gnt=0 after the first cycle.
  - Raise out_ready: handshake, then lane 3 loads at the same edge.
- Pointer wrap: after a grant to lane 7 (ptr=0), req=8'h81.
  - Grants lane 0, then lane 7, then lane 0.
- Reset mid-transfer: rst_n=0 for one cycle while in SEND with out_ready=0.
  - Next edge: out_valid=0, out_data=0, sel=0, ptr=0, no gnt.
  - Pending req is served from lane 0 priority after release.
